// File: rtl/hansen_uart_tx.sv
// hansen_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
//
// Register window (addr[3:2] selects, addr[1:0] ignored):
//   0x0 TXDATA  write pushes wdata[7:0]; reads 0
//   0x4 STATUS  {count[15:8], overflow[3], full[2], empty[1], busy[0]};
//               writing 1 to bit3 clears overflow
//   0x8 DIV     bit period in clocks; a write of 0 is ignored
//   0xC CTRL    {irq_en[1], enable[0]}, reset value 0x1
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   sel, addr, we  register window select, byte address, write strobe
//   wdata, rdata   write data in, combinational read data out (0 when !sel)
//   uart_tx        registered serial line, idle high
//   irq            registered level interrupt: irq_en & empty & ~busy
module hansen_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t state, state_next;

    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 overflow, enable, irq_en;
    logic [DIV_WIDTH-1:0] div_reg, bit_period, bit_timer;
    logic [7:0]           shift_reg;
    logic [2:0]           bit_idx;

    logic empty, full, busy;
    logic bus_wr, push_req, push, pop, can_pop, bit_done, tx_next;
    logic unused_bits;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign bus_wr   = sel & we;
    assign push_req = bus_wr & (addr[3:2] == REG_TXDATA);
    // Full is judged on the registered count, so a push while full is dropped
    // even when a pop frees a slot on the same edge.
    assign push     = push_req & ~full;
    assign can_pop  = enable & ~empty;
    assign bit_done = busy & (bit_timer == '0);

    // Only parts of addr/wdata are decoded; fold the rest so nothing dangles.
    assign unused_bits = ^{addr[1:0], wdata};

    // ---------------- control registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= DIV_WIDTH'(DEFAULT_DIV);
            enable  <= 1'b1;
            irq_en  <= 1'b0;
        end else if (bus_wr) begin
            if (addr[3:2] == REG_DIV && wdata[DIV_WIDTH-1:0] != '0)
                div_reg <= wdata[DIV_WIDTH-1:0];
            if (addr[3:2] == REG_CTRL) begin
                enable <= wdata[0];
                irq_en <= wdata[1];
            end
        end
    end

    // ---------------- FIFO ----------------
    // NOTE: the FIFO storage has no reset; reset empties it via pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push_req && full)
                overflow <= 1'b1;
            else if (bus_wr && addr[3:2] == REG_STATUS && wdata[3])
                overflow <= 1'b0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output is given a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (can_pop) state_next = START;
            START:   if (bit_done) state_next = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) state_next = STOP;
            STOP:    if (bit_done) state_next = can_pop ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // tx_next is the line level for the cycle after this edge, which keeps
    // uart_tx registered without adding a cycle of latency to the start bit.
    always_comb begin
        pop     = can_pop & ((state == IDLE) | ((state == STOP) & bit_done));
        tx_next = uart_tx;
        if (pop) begin
            tx_next = 1'b0;
        end else if (bit_done) begin
            case (state)
                START:   tx_next = shift_reg[0];
                DATA:    tx_next = (bit_idx == 3'd7) ? 1'b1 : shift_reg[1];
                default: tx_next = 1'b1;
            endcase
        end
    end

    // ---------------- bit timing and shifter ----------------
    // The bit period is snapshotted at each pop, so DIV writes mid-frame only
    // affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_period <= '0;
            bit_timer  <= '0;
            bit_idx    <= '0;
            uart_tx    <= 1'b1;
            irq        <= 1'b0;
        end else begin
            if (pop) begin
                shift_reg  <= fifo_mem[rd_ptr];
                bit_period <= div_reg;
                bit_timer  <= div_reg - DIV_ONE;
                bit_idx    <= '0;
            end else if (bit_done) begin
                bit_timer <= bit_period - DIV_ONE;
                if (state == DATA) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 3'd1;
                end
            end else if (busy) begin
                bit_timer <= bit_timer - DIV_ONE;
            end
            uart_tx <= tx_next;
            irq     <= irq_en & empty & ~busy;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                REG_STATUS: rdata = {16'b0, 8'(count), 4'b0, overflow, full, empty, busy};
                REG_DIV:    rdata = 32'(div_reg);
                REG_CTRL:   rdata = {30'b0, irq_en, enable};
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hansen_uart_tx.sv
// tb_hansen_uart_tx: directed self-checking bench for hansen_uart_tx.
// A register-access table covers reset values and simple register behaviour;
// hand-written sequences cover frame timing, back-to-back frames, overflow,
// DIV snapshot / enable gating / irq, and reset in the middle of a frame.
module tb_hansen_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        uart_tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    hansen_uart_tx dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .uart_tx (uart_tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        sel;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic s, input logic [3:0] a, output logic [31:0] d);
        sel  = s;
        we   = 1'b0;
        addr = a;
        #1;
        d    = rdata;
        sel  = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(1'b1, a, d);
        check(name, d, exp);
    endtask

    // Samples uart_tx once per cycle from frame cycle start_idx to the end of
    // the frame; the current falling edge is frame cycle start_idx.
    task automatic check_frame(input logic [7:0] data, input int div, input int start_idx,
                               input string name);
        int   b;
        logic e;
        for (int i = start_idx; i < 10 * div; i++) begin
            b = i / div;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = data[b-1];
            check(name, {31'b0, uart_tx}, {31'b0, e});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        got;

        vecs[0]  = '{"reset_status",      1'b1, 1'b0, 4'h4, 32'h0, 32'h0000_0002};
        vecs[1]  = '{"reset_div",         1'b1, 1'b0, 4'h8, 32'h0, 32'd868};
        vecs[2]  = '{"reset_ctrl",        1'b1, 1'b0, 4'hC, 32'h0, 32'h0000_0001};
        vecs[3]  = '{"txdata_reads_zero", 1'b1, 1'b0, 4'h0, 32'h0, 32'h0};
        vecs[4]  = '{"rdata_unselected",  1'b0, 1'b0, 4'h4, 32'h0, 32'h0};
        vecs[5]  = '{"addr_low_ignored",  1'b1, 1'b0, 4'h6, 32'h0, 32'h0000_0002};
        vecs[6]  = '{"div_zero_ignored",  1'b1, 1'b1, 4'h8, 32'h0, 32'd868};
        vecs[7]  = '{"div_write",         1'b1, 1'b1, 4'h8, 32'd4, 32'd4};
        vecs[8]  = '{"ctrl_write_2",      1'b1, 1'b1, 4'hC, 32'h2, 32'h2};
        vecs[9]  = '{"ctrl_write_1",      1'b1, 1'b1, 4'hC, 32'h1, 32'h1};
        vecs[10] = '{"status_read_only",  1'b1, 1'b1, 4'h4, 32'hFFFF_FFF7, 32'h0000_0002};

        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_irq",     {31'b0, irq},     32'h0);

        // ---------- register table ----------
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].sel, vecs[i].addr, d);
            check(vecs[i].name, d, vecs[i].exp);
        end

        // ---------- single frame, DIV=4, 0xA5 ----------
        bus_write(4'h0, 32'hA5);
        check("single_tx_idle_at_write", {31'b0, uart_tx}, 32'h1);
        check_reg("single_status_queued", 4'h4, 32'h0000_0100);
        @(negedge clk);
        check_reg("single_status_popped", 4'h4, 32'h0000_0003);
        check_frame(8'hA5, 4, 0, "single_frame_A5");
        check_reg("single_busy_clear", 4'h4, 32'h0000_0002);
        check("single_tx_idle_after", {31'b0, uart_tx}, 32'h1);

        // ---------- back-to-back frames ----------
        bus_write(4'h0, 32'h01);
        bus_write(4'h0, 32'h02);
        bus_write(4'h0, 32'h03);
        check_reg("b2b_status_count2", 4'h4, 32'h0000_0201);
        check_frame(8'h01, 4, 1, "b2b_frame_01");
        check_frame(8'h02, 4, 0, "b2b_frame_02");
        check_frame(8'h03, 4, 0, "b2b_frame_03");
        check_reg("b2b_idle_after", 4'h4, 32'h0000_0002);
        check("b2b_irq_disabled", {31'b0, irq}, 32'h0);

        // ---------- overflow ----------
        bus_write(4'hC, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(4'h0, 32'h10 + 32'(i));
        check_reg("ovf_status_full", 4'h4, 32'h0000_080C);
        bus_write(4'h4, 32'h8);
        check_reg("ovf_cleared", 4'h4, 32'h0000_0804);
        // Enable, then push while still full on the same edge as the first pop.
        bus_write(4'hC, 32'h1);
        bus_write(4'h0, 32'h99);
        check_reg("ovf_push_during_pop", 4'h4, 32'h0000_0709);
        for (int i = 0; i < 8; i++)
            check_frame(8'h10 + 8'(i), 4, 0, $sformatf("ovf_frame_%0d", i));
        check_reg("ovf_sticky_after", 4'h4, 32'h0000_000A);
        bus_write(4'h4, 32'h8);
        check_reg("ovf_final_clear", 4'h4, 32'h0000_0002);
        check("ovf_tx_idle", {31'b0, uart_tx}, 32'h1);

        // ---------- DIV change and enable mid-frame ----------
        bus_write(4'h0, 32'h3C);
        bus_write(4'h0, 32'hC3);
        bus_write(4'h8, 32'd6);
        bus_write(4'hC, 32'h2);
        check_frame(8'h3C, 4, 2, "div_frame_3C_at_4");
        repeat (5) begin
            check("div_held_tx_idle", {31'b0, uart_tx}, 32'h1);
            @(negedge clk);
        end
        check_reg("div_held_status", 4'h4, 32'h0000_0100);
        check_reg("div_new_value", 4'h8, 32'd6);
        check("div_irq_while_queued", {31'b0, irq}, 32'h0);
        bus_write(4'hC, 32'h3);
        check("div_tx_before_pop", {31'b0, uart_tx}, 32'h1);
        @(negedge clk);
        check("div_irq_during_frame", {31'b0, irq}, 32'h0);
        check_frame(8'hC3, 6, 0, "div_frame_C3_at_6");
        got = 1'b0;
        for (int k = 0; k < 3 && !got; k++) begin
            if (irq) got = 1'b1;
            else     @(negedge clk);
        end
        check("irq_after_stop", {31'b0, got}, 32'h1);

        // ---------- reset mid-frame ----------
        bus_write(4'h0, 32'h5A);
        bus_write(4'h0, 32'h6B);
        repeat (6) @(negedge clk);
        check("rst_in_data_low_bit", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx_high", {31'b0, uart_tx}, 32'h1);
        check_reg("rst_status_flushed", 4'h4, 32'h0000_0002);
        check("rst_irq_low", {31'b0, irq}, 32'h0);
        check_reg("rst_div_default", 4'h8, 32'd868);
        check_reg("rst_ctrl_default", 4'hC, 32'h1);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_no_resume", {31'b0, uart_tx}, 32'h1);
        check_reg("rst_still_empty", 4'h4, 32'h0000_0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
